bist_engine: RTL and testbench

BIST_ENGINE -- requirements
Module: bist_engine

---
 rtl/bist_pkg.sv | 26 ++
 rtl/bist_misr.sv | 35 +++
 rtl/bist_engine.sv | 153 +++++++++++++++
 tb/tb_bist_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the logic BIST engine.
//   bist_state_t  : controller state encoding
//   DEF_*_TAPS    : default Fibonacci LFSR and MISR feedback masks
//   cnt_width()   : width for a counter that must hold a given terminal value
package bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } bist_state_t;

    localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
    localparam logic [20:0] DEF_MISR_TAPS = 21'h140000;

    // One spare bit over clog2 so the terminal value itself is representable
    // and a counter can never wrap inside a test.
    function automatic int cnt_width(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr: multiple-input signature register.
//   clk, rst_n : clock, asynchronous active-low reset (clears the signature)
//   clear      : synchronous clear to zero (test seeding)
//   enable     : compact data_in into the signature this cycle
//   data_in    : WIDTH-bit parallel input, already zero-extended by the caller
//   signature  : current register contents
module bist_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH = 21,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_MISR_TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] signature
);

    logic feedback;

    assign feedback = ^(signature & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            signature <= '0;
        end else if (clear) begin
            signature <= '0;
        end else if (enable) begin
            signature <= {signature[WIDTH-2:0], feedback} ^ data_in;
        end
    end

endmodule

// File: rtl/bist_engine.sv
// bist_engine: scan-based logic BIST controller.
//   clk, rst_n    : clock, asynchronous active-low reset
//   bist_start    : level request; sampled only in IDLE (and DONE, to leave it)
//   func_pi       : functional primary inputs, passed to cut_pi when idle
//   cut_pi        : CUT primary inputs (LFSR bits above the chain bits while running)
//   cut_scan_en   : scan enable, high during SHIFT and UNLOAD
//   cut_scan_in   : chain inputs, LFSR[N_CH-1:0]
//   cut_scan_out  : chain outputs, compacted into the MISR
//   cut_po        : CUT primary outputs, compacted into the MISR
//   running       : test in progress (any state but IDLE/DONE)
//   bist_end      : test complete (DONE)
//   pass_fail     : final signature matched GOLDEN
//   signature     : live MISR contents
module bist_engine
    import bist_pkg::*;
#(
    parameter int                N_CH      = 2,
    parameter int                N_PI      = 3,
    parameter int                N_PO      = 2,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(DEF_LFSR_TAPS),
    parameter int                MISR_W    = 21,
    parameter logic [MISR_W-1:0] MISR_TAPS = MISR_W'(DEF_MISR_TAPS),
    parameter int                SHIFT_LEN = 4,
    parameter int                N_PAT     = 8,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(1),
    parameter logic [MISR_W-1:0] GOLDEN    = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bist_start,
    input  logic [N_PI-1:0]   func_pi,
    output logic [N_PI-1:0]   cut_pi,
    output logic              cut_scan_en,
    output logic [N_CH-1:0]   cut_scan_in,
    input  logic [N_CH-1:0]   cut_scan_out,
    input  logic [N_PO-1:0]   cut_po,
    output logic              running,
    output logic              bist_end,
    output logic              pass_fail,
    output logic [MISR_W-1:0] signature
);

    localparam int SC_W = cnt_width(SHIFT_LEN);
    localparam int PC_W = cnt_width(N_PAT);

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SHIFT_LEN - 1);
    localparam logic [PC_W-1:0] PC_TERM = PC_W'(N_PAT);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    bist_state_t       state;
    bist_state_t       state_next;
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_step;
    logic [SC_W-1:0]   shift_cnt;
    logic [PC_W-1:0]   pat_cnt;
    logic [PC_W-1:0]   pat_inc;
    logic              shift_last;
    logic              misr_clear;
    logic              misr_enable;
    logic [MISR_W-1:0] misr_in;

    assign lfsr_step  = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    assign shift_last = (shift_cnt == SC_LAST);
    assign pat_inc    = pat_cnt + PC_W'(1);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (bist_start) state_next = ST_SEED;
            ST_SEED:    state_next = ST_SHIFT;
            ST_SHIFT:   if (shift_last) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = (pat_inc == PC_TERM) ? ST_UNLOAD : ST_SHIFT;
            ST_UNLOAD:  if (shift_last) state_next = ST_COMPARE;
            ST_COMPARE: state_next = ST_DONE;
            ST_DONE:    if (!bist_start) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the current state only
    always_comb begin
        running     = (state != ST_IDLE) && (state != ST_DONE);
        bist_end    = (state == ST_DONE);
        cut_scan_en = (state == ST_SHIFT) || (state == ST_UNLOAD);
        misr_clear  = (state == ST_SEED);
        misr_enable = (state == ST_SHIFT) || (state == ST_CAPTURE) || (state == ST_UNLOAD);
    end

    // Pattern generator, counters and verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr      <= LFSR_W'(1);
            shift_cnt <= '0;
            pat_cnt   <= '0;
            pass_fail <= 1'b0;
        end else begin
            case (state)
                ST_SEED: begin
                    lfsr      <= SEED_EFF;
                    shift_cnt <= '0;
                    pat_cnt   <= '0;
                    pass_fail <= 1'b0;
                end
                ST_SHIFT, ST_UNLOAD: begin
                    lfsr      <= lfsr_step;
                    shift_cnt <= shift_last ? '0 : shift_cnt + SC_W'(1);
                end
                ST_CAPTURE: begin
                    pat_cnt <= pat_inc;
                end
                ST_COMPARE: begin
                    pass_fail <= (signature == GOLDEN);
                end
                default: ;
            endcase
        end
    end

    assign cut_scan_in = lfsr[N_CH-1:0];
    assign cut_pi      = running ? lfsr[N_CH+N_PI-1:N_CH] : func_pi;

    // Chain outputs occupy the low bits, primary outputs sit directly above.
    always_comb begin
        misr_in                  = '0;
        misr_in[N_CH+N_PO-1:0]   = {cut_po, cut_scan_out};
    end

    bist_misr #(
        .WIDTH (MISR_W),
        .TAPS  (MISR_TAPS)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (misr_clear),
        .enable    (misr_enable),
        .data_in   (misr_in),
        .signature (signature)
    );

endmodule

// File: tb/tb_bist_engine.sv
module tb_bist_engine;

    // Expected signature of a whole test, derived from the test definition:
    // every cycle of SHIFT, CAPTURE and UNLOAD compacts {po, scan_out} into
    // the MISR, and the LFSR advances on all of them except the capture
    // cycle closing each pattern. The CUT loops scan_in back to scan_out.
    function automatic logic [20:0] ref_sig(input int n_ch, input int sl, input int np,
                                            input logic stk, input logic [127:0] pob);
        logic [15:0] l;
        logic [15:0] so;
        logic [20:0] m;
        logic [20:0] din;
        int          steps;
        l = 16'd1;
        m = '0;
        steps = np * (sl + 1) + sl;
        for (int i = 0; i < steps; i++) begin
            so = l & ((16'd1 << n_ch) - 16'd1);
            if (stk) so[1] = 1'b0;
            din = 21'(so) | (21'(pob[2*i +: 2]) << n_ch);
            m = {m[19:0], ^(m & 21'h140000)} ^ din;
            if (i >= np * (sl + 1) || (i % (sl + 1)) != sl)
                l = {l[14:0], ^(l & 16'hB400)};
        end
        return m;
    endfunction

    function automatic logic [15:0] lstep(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    // Activity t cycles after the start is sampled:
    // 0 seed, 1 shift, 2 capture, 3 unload, 4 compare.
    function automatic int phase(input int t, input int sl, input int np);
        if (t == 0) return 0;
        if (t <= np * (sl + 1)) return (((t - 1) % (sl + 1)) < sl) ? 1 : 2;
        if (t <= np * (sl + 1) + sl) return 3;
        return 4;
    endfunction

    localparam logic [20:0] GOLD_D = ref_sig(2, 4, 8, 1'b0, 128'd0);
    localparam logic [20:0] GOLD_A = ref_sig(4, 7, 3, 1'b0, 128'd0);
    localparam int LAT_D = 2 + 8 * (4 + 1) + 4;
    localparam int LAT_A = 2 + 3 * (7 + 1) + 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stuck = 1'b0;
    int          total = 0;
    int          bad = 0;

    logic        d_start = 1'b0;
    logic [2:0]  d_func = 3'b011;
    logic [2:0]  d_pi;
    logic        d_scan_en;
    logic [1:0]  d_si;
    logic [1:0]  d_so;
    logic [1:0]  d_po = 2'b00;
    logic        d_running;
    logic        d_end;
    logic        d_pf;
    logic [20:0] d_sig;

    logic        a_start = 1'b0;
    logic [2:0]  a_func = 3'b000;
    logic [2:0]  a_pi;
    logic        a_scan_en;
    logic [3:0]  a_si;
    logic [1:0]  a_po = 2'b00;
    logic        a_running;
    logic        a_end;
    logic        a_pf;
    logic [20:0] a_sig;

    always #5 clk = ~clk;

    always_comb begin
        d_so = d_si;
        if (stuck) d_so[1] = 1'b0;
    end

    bist_engine #(.GOLDEN(GOLD_D)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bist_start   (d_start),
        .func_pi      (d_func),
        .cut_pi       (d_pi),
        .cut_scan_en  (d_scan_en),
        .cut_scan_in  (d_si),
        .cut_scan_out (d_so),
        .cut_po       (d_po),
        .running      (d_running),
        .bist_end     (d_end),
        .pass_fail    (d_pf),
        .signature    (d_sig)
    );

    bist_engine #(.N_CH(4), .SHIFT_LEN(7), .N_PAT(3), .GOLDEN(GOLD_A)) u_alt (
        .clk          (clk),
        .rst_n        (rst_n),
        .bist_start   (a_start),
        .func_pi      (a_func),
        .cut_pi       (a_pi),
        .cut_scan_en  (a_scan_en),
        .cut_scan_in  (a_si),
        .cut_scan_out (a_si),
        .cut_po       (a_po),
        .running      (a_running),
        .bist_end     (a_end),
        .pass_fail    (a_pf),
        .signature    (a_sig)
    );

    task automatic test_reset();
        #12;
        total++; if (d_running !== 1'b0) begin bad++; $display("FAIL rst_running got=%b want=0", d_running); end
        total++; if (d_end !== 1'b0) begin bad++; $display("FAIL rst_end got=%b want=0", d_end); end
        total++; if (d_pf !== 1'b0) begin bad++; $display("FAIL rst_pf got=%b want=0", d_pf); end
        total++; if (d_scan_en !== 1'b0) begin bad++; $display("FAIL rst_scan_en got=%b want=0", d_scan_en); end
        total++; if (d_sig !== 21'd0) begin bad++; $display("FAIL rst_sig got=%h want=0", d_sig); end
        total++; if (d_si !== 2'b01) begin bad++; $display("FAIL rst_scan_in got=%b want=01", d_si); end
        total++; if (d_pi !== d_func) begin bad++; $display("FAIL rst_cut_pi got=%b want=%b", d_pi, d_func); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d_func = 3'($urandom);
            @(negedge clk);
            total++; if (d_running !== 1'b0) begin bad++; $display("FAIL idle_running got=%b want=0", d_running); end
            total++; if (d_pi !== d_func) begin bad++; $display("FAIL idle_cut_pi got=%b want=%b", d_pi, d_func); end
        end
    endtask

    // One self-test on the default instance. stk: chain 1 stuck-at-0;
    // rnd_po: random primary outputs; hold: keep bist_start high throughout;
    // rst_at: cycle at which reset is applied (-1 for none).
    task automatic run_default(input logic stk, input logic rnd_po, input logic hold, input int rst_at);
        logic [127:0] pob;
        logic [15:0]  ml;
        logic [20:0]  exp_sig;
        int           ph;
        pob = '0;
        ml = 16'd1;
        if (rnd_po) for (int i = 0; i < 64; i++) pob[2*i +: 2] = 2'($urandom);
        exp_sig = ref_sig(2, 4, 8, stk, pob);
        stuck = stk;
        @(negedge clk);
        d_start = 1'b1;
        @(negedge clk);
        if (!hold) d_start = 1'b0;
        for (int t = 0; t < LAT_D; t++) begin
            ph = phase(t, 4, 8);
            total++; if (d_running !== 1'b1) begin bad++; $display("FAIL run_running t=%0d got=%b want=1", t, d_running); end
            total++; if (d_end !== 1'b0) begin bad++; $display("FAIL run_end t=%0d got=%b want=0", t, d_end); end
            total++; if (d_scan_en !== (ph == 1 || ph == 3)) begin bad++; $display("FAIL run_scan_en t=%0d got=%b want=%b", t, d_scan_en, (ph == 1 || ph == 3)); end
            if (t >= 1) begin
                total++; if (d_si !== ml[1:0]) begin bad++; $display("FAIL run_scan_in t=%0d got=%b want=%b", t, d_si, ml[1:0]); end
                total++; if (d_pi !== ml[4:2]) begin bad++; $display("FAIL run_cut_pi t=%0d got=%b want=%b", t, d_pi, ml[4:2]); end
            end
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                total++; if (d_running !== 1'b0) begin bad++; $display("FAIL mid_rst_running got=%b want=0", d_running); end
                total++; if (d_end !== 1'b0) begin bad++; $display("FAIL mid_rst_end got=%b want=0", d_end); end
                total++; if (d_pf !== 1'b0) begin bad++; $display("FAIL mid_rst_pf got=%b want=0", d_pf); end
                total++; if (d_scan_en !== 1'b0) begin bad++; $display("FAIL mid_rst_scan_en got=%b want=0", d_scan_en); end
                total++; if (d_sig !== 21'd0) begin bad++; $display("FAIL mid_rst_sig got=%h want=0", d_sig); end
                total++; if (d_si !== 2'b01) begin bad++; $display("FAIL mid_rst_scan_in got=%b want=01", d_si); end
                total++; if (d_pi !== d_func) begin bad++; $display("FAIL mid_rst_cut_pi got=%b want=%b", d_pi, d_func); end
                d_start = 1'b0;
                d_po = 2'b00;
                @(negedge clk);
                rst_n = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    total++; if (d_running !== 1'b0) begin bad++; $display("FAIL post_rst_running got=%b want=0", d_running); end
                end
                return;
            end
            d_po = (ph >= 1 && ph <= 3) ? pob[2*(t-1) +: 2] : 2'b00;
            d_func = 3'($urandom);
            @(negedge clk);
            if (ph == 1 || ph == 3) ml = lstep(ml);
        end
        d_po = 2'b00;
        total++; if (d_end !== 1'b1) begin bad++; $display("FAIL done_end got=%b want=1", d_end); end
        total++; if (d_running !== 1'b0) begin bad++; $display("FAIL done_running got=%b want=0", d_running); end
        total++; if (d_scan_en !== 1'b0) begin bad++; $display("FAIL done_scan_en got=%b want=0", d_scan_en); end
        total++; if (d_sig !== exp_sig) begin bad++; $display("FAIL done_sig got=%h want=%h", d_sig, exp_sig); end
        total++; if (d_pf !== (exp_sig == GOLD_D)) begin bad++; $display("FAIL done_pf got=%b want=%b", d_pf, (exp_sig == GOLD_D)); end
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                total++; if (d_end !== 1'b1) begin bad++; $display("FAIL hold_end got=%b want=1", d_end); end
                total++; if (d_running !== 1'b0) begin bad++; $display("FAIL hold_running got=%b want=0", d_running); end
            end
            d_start = 1'b0;
            d_func = 3'b101;
        end
        @(negedge clk);
        total++; if (d_end !== 1'b0) begin bad++; $display("FAIL idle_end got=%b want=0", d_end); end
        total++; if (d_running !== 1'b0) begin bad++; $display("FAIL idle_running got=%b want=0", d_running); end
        total++; if (d_pf !== (exp_sig == GOLD_D)) begin bad++; $display("FAIL idle_pf_kept got=%b want=%b", d_pf, (exp_sig == GOLD_D)); end
        total++; if (d_pi !== d_func) begin bad++; $display("FAIL idle_cut_pi got=%b want=%b", d_pi, d_func); end
    endtask

    task automatic test_random_po();
        run_default(1'b0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_stuck_at();
        run_default(1'b1, 1'b0, 1'b0, -1);
        total++; if (d_pf !== 1'b0) begin bad++; $display("FAIL stuck_pf got=%b want=0", d_pf); end
        total++; if (d_sig === GOLD_D) begin bad++; $display("FAIL stuck_sig got=%h want!=%h", d_sig, GOLD_D); end
    endtask

    task automatic test_golden();
        run_default(1'b0, 1'b0, 1'b0, -1);
        total++; if (d_pf !== 1'b1) begin bad++; $display("FAIL golden_pf got=%b want=1", d_pf); end
        total++; if (d_sig !== GOLD_D) begin bad++; $display("FAIL golden_sig got=%h want=%h", d_sig, GOLD_D); end
    endtask

    task automatic test_midtest_reset();
        // Reset in IDLE while a pass verdict is held clears it.
        rst_n = 1'b0;
        #1;
        total++; if (d_pf !== 1'b0) begin bad++; $display("FAIL idle_rst_pf got=%b want=0", d_pf); end
        @(negedge clk);
        rst_n = 1'b1;
        run_default(1'b0, 1'b0, 1'b0, 20);
        run_default(1'b0, 1'b0, 1'b1, -1);
        total++; if (d_sig !== GOLD_D) begin bad++; $display("FAIL rerun_sig got=%h want=%h", d_sig, GOLD_D); end
    endtask

    task automatic test_alt_config();
        logic [15:0] ml;
        int          ph;
        ml = 16'd1;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int t = 0; t < LAT_A; t++) begin
            ph = phase(t, 7, 3);
            total++; if (a_running !== 1'b1) begin bad++; $display("FAIL alt_running t=%0d got=%b want=1", t, a_running); end
            total++; if (a_end !== 1'b0) begin bad++; $display("FAIL alt_end t=%0d got=%b want=0", t, a_end); end
            total++; if (a_scan_en !== (ph == 1 || ph == 3)) begin bad++; $display("FAIL alt_scan_en t=%0d got=%b want=%b", t, a_scan_en, (ph == 1 || ph == 3)); end
            if (ph == 1) begin
                total++; if (a_si !== ml[3:0]) begin bad++; $display("FAIL alt_scan_in t=%0d got=%h want=%h", t, a_si, ml[3:0]); end
            end
            if (t >= 1) begin
                total++; if (a_pi !== ml[6:4]) begin bad++; $display("FAIL alt_cut_pi t=%0d got=%b want=%b", t, a_pi, ml[6:4]); end
            end
            a_func = 3'($urandom);
            @(negedge clk);
            if (ph == 1 || ph == 3) ml = lstep(ml);
        end
        total++; if (a_end !== 1'b1) begin bad++; $display("FAIL alt_done_end got=%b want=1", a_end); end
        total++; if (a_sig !== GOLD_A) begin bad++; $display("FAIL alt_sig got=%h want=%h", a_sig, GOLD_A); end
        total++; if (a_pf !== 1'b1) begin bad++; $display("FAIL alt_pf got=%b want=1", a_pf); end
        @(negedge clk);
        total++; if (a_end !== 1'b0) begin bad++; $display("FAIL alt_idle_end got=%b want=0", a_end); end
    endtask

    initial begin
        test_reset();
        test_random_po();
        test_stuck_at();
        test_golden();
        test_midtest_reset();
        test_alt_config();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
